// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and
// the registered flag bundle.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLA = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_DBL = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_mc_param_if.sv
// Operand/opcode request and result/flag response bundle of the ALU.
interface alu_mc_param_if #(
    parameter int WIDTH = 16
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [WIDTH-1:0] alu;
    logic             busy;
    logic             done;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             illegal;

    modport master (
        output start, a, b, op,
        input  alu, busy, done, zero, neg, carry, ovf, illegal
    );

    modport slave (
        input  start, a, b, op,
        output alu, busy, done, zero, neg, carry, ovf, illegal
    );

endinterface

// File: rtl/alu_mc_shift_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only built when ALU_MC_MUL_EN is defined.
`ifdef ALU_MC_MUL_EN
module alu_mc_shift_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     part;

    // acc = {partial high, remaining multiplier bits}; shifted right each step
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done    = 1'b0;
        part    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, mcand_q} : '0);
        if (start) begin
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            acc_d = {part, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(WIDTH)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // product is valid in the done cycle, ahead of the final acc update
    assign busy    = busy_q;
    assign product = acc_d;

endmodule
`endif

// File: rtl/alu_mc_param.sv
// Multi-cycle parametrised ALU with registered result/flags and start/done.
// Define ALU_MC_MUL_EN to build the iterative multiplier (op 1010).
module alu_mc_param
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             input_CLK,
    input  logic             input_Reset,
    input  logic             input_Start,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [3:0]       input_ALUOp,
    output logic [WIDTH-1:0] output_ALU,
    output logic             output_Busy,
    output logic             output_Done,
    output logic             output_Zero,
    output logic             output_Negative,
    output logic             output_Carry,
    output logic             output_Overflow,
    output logic             output_Illegal
);

    localparam int M = WIDTH - 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       sum, diff, shl, shr;
    logic signed [WIDTH:0] sar;
    logic [WIDTH-1:0]     alu_res;
    alu_flags_t           alu_flg;
    logic                 is_mul;

`ifdef ALU_MC_MUL_EN
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mc_shift_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (input_CLK),
        .rst     (input_Reset),
        .start   (mul_start),
        .a       (input_A),
        .b       (input_B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_comb begin
        sh      = input_B[SHW-1:0];
        sum     = {1'b0, input_A} + {1'b0, input_B};
        diff    = {1'b0, input_A} - {1'b0, input_B};
        shl     = {1'b0, input_A} << sh;
        shr     = {input_A, 1'b0} >> sh;
        sar     = $signed({input_A, 1'b0}) >>> sh;
        alu_res = '0;
        alu_flg = '0;
        unique case (input_ALUOp)
            OP_ADD: begin
                alu_res       = sum[M:0];
                alu_flg.carry = sum[WIDTH];
                alu_flg.ovf   = (input_A[M] == input_B[M])
                              && (sum[M] != input_A[M]);
            end
            OP_SUB: begin
                alu_res       = diff[M:0];
                alu_flg.carry = diff[WIDTH];
                alu_flg.ovf   = (input_A[M] != input_B[M])
                              && (diff[M] != input_A[M]);
            end
            OP_AND: alu_res = input_A & input_B;
            OP_OR:  alu_res = input_A | input_B;
            OP_XOR: alu_res = input_A ^ input_B;
            OP_SLL, OP_SLA: begin
                alu_res       = shl[M:0];
                alu_flg.carry = shl[WIDTH];
            end
            OP_SRL: begin
                alu_res       = shr[WIDTH:1];
                alu_flg.carry = shr[0];
            end
            OP_SRA: begin
                alu_res       = sar[WIDTH:1];
                alu_flg.carry = sar[0];
            end
            // (A+B)<<1: bits WIDTH and WIDTH+1 are sum[M] and sum[WIDTH]
            OP_DBL: begin
                alu_res       = {sum[M-1:0], 1'b0};
                alu_flg.carry = sum[WIDTH] | sum[M];
            end
            default: alu_flg.illegal = 1'b1;
        endcase
        alu_flg.zero = (alu_res == '0);
        alu_flg.neg  = alu_res[M];
    end

`ifdef ALU_MC_MUL_EN
    assign is_mul = (input_ALUOp == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_MC_MUL_EN
        mul_start = 1'b0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (input_Start && is_mul) begin
                    state_d = MUL;
`ifdef ALU_MC_MUL_EN
                    mul_start = 1'b1;
`endif
                end else if (input_Start) begin
                    state_d  = DONE;
                    result_d = alu_res;
                    flags_d  = alu_flg;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
`ifdef ALU_MC_MUL_EN
                if (mul_done) begin
                    state_d       = DONE;
                    result_d      = mul_prod[M:0];
                    flags_d       = '0;
                    flags_d.carry = |mul_prod[2*WIDTH-1:WIDTH];
                    flags_d.zero  = (mul_prod[M:0] == '0);
                    flags_d.neg   = mul_prod[M];
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge input_CLK) begin
        if (input_Reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign output_ALU      = result_q;
    assign output_Done     = (state_q == DONE);
    assign output_Zero     = flags_q.zero;
    assign output_Negative = flags_q.neg;
    assign output_Carry    = flags_q.carry;
    assign output_Overflow = flags_q.ovf;
    assign output_Illegal  = flags_q.illegal;
`ifdef ALU_MC_MUL_EN
    assign output_Busy = (state_q == MUL) && mul_busy;
`else
    assign output_Busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mc_param.sv
// Randomised self-checking bench for alu_mc_param (WIDTH=16) against an
// arithmetic reference model; follows ALU_MC_MUL_EN when defined.
module tb_alu_mc_param;

    localparam int W = 16;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint MASK = 64'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_mc_param_if #(.WIDTH(W)) bus ();

    alu_mc_param #(.WIDTH(W)) dut (
        .input_CLK       (clk),
        .input_Reset     (rst),
        .input_Start     (bus.start),
        .input_A         (bus.a),
        .input_B         (bus.b),
        .input_ALUOp     (bus.op),
        .output_ALU      (bus.alu),
        .output_Busy     (bus.busy),
        .output_Done     (bus.done),
        .output_Zero     (bus.zero),
        .output_Negative (bus.neg),
        .output_Carry    (bus.carry),
        .output_Overflow (bus.ovf),
        .output_Illegal  (bus.illegal)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operands
    function automatic void model(input int op, input longint a,
                                  input longint b, output longint res,
                                  output bit c, output bit v,
                                  output bit il, output int lat);
        longint sa, sb, t;
        int     sh;
        sa  = (a >= 32768) ? a - 65536 : a;
        sb  = (b >= 32768) ? b - 65536 : b;
        sh  = int'(b % 16);
        res = 0; c = 0; v = 0; il = 0; lat = 1;
        case (op)
            0: begin
                t = a + b; res = t & MASK; c = (t > 65535);
                t = sa + sb; v = (t < -32768) || (t > 32767);
            end
            1: begin
                res = (a - b) & MASK; c = (a < b);
                t = sa - sb; v = (t < -32768) || (t > 32767);
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5, 7: begin
                res = (a << sh) & MASK;
                c = (sh != 0) && (((a >> (16 - sh)) & 1) != 0);
            end
            6: begin
                res = a >> sh;
                c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0);
            end
            8: begin
                res = (sa >>> sh) & MASK;
                c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0);
            end
            9: begin
                t = (a + b) * 2; res = t & MASK; c = (t > 65535);
            end
            10: begin
                if (MUL_EN) begin
                    t = a * b; res = t & MASK; c = ((t >> 16) != 0);
                    lat = W + 1;
                end else begin
                    il = 1;
                end
            end
            default: il = 1;
        endcase
    endfunction

    // Issue one op from mid-cycle and wait (bounded) for Done
    task automatic run_op(input int op, input longint a, input longint b,
                          input bit poke, input string tag);
        longint er;
        bit     ec, ev, ei;
        int     el, lat, bc;
        model(op, a, b, er, ec, ev, ei, el);
        bus.start = 1'b1;
        bus.a     = 16'(a);
        bus.b     = 16'(b);
        bus.op    = 4'(op);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bc++;
            if (poke && lat == 4) begin
                bus.start = 1'b1;
                bus.a     = 16'hFFFF;
                bus.b     = 16'h0003;
                bus.op    = 4'b0000;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " busy_cycles"}, 64'(bc), 64'(el - 1));
        check({tag, " result"}, 64'(bus.alu), 64'(er));
        check({tag, " carry"}, 64'(bus.carry), 64'(ec));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(ev));
        check({tag, " illegal"}, 64'(bus.illegal), 64'(ei));
        check({tag, " zero"}, 64'(bus.zero), 64'(er == 0));
        check({tag, " neg"}, 64'(bus.neg), 64'((er >> 15) & 1));
    endtask

    initial begin
        int     seen;
        int     op;
        longint a, b;
        longint edge_v[4];
        edge_v[0] = 0; edge_v[1] = 'h7FFF;
        edge_v[2] = 'h8000; edge_v[3] = 'hFFFF;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset alu", 64'(bus.alu), 0);
        check("reset flags", 64'({bus.done, bus.busy, bus.zero, bus.neg,
              bus.carry, bus.ovf, bus.illegal}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle outputs", 64'({bus.alu, bus.done, bus.busy, bus.zero,
              bus.illegal}), 0);

        run_op(0, 'h7FFF, 'h0001, 1'b0, "add_ovf");
        run_op(1, 'h0003, 'h0005, 1'b0, "sub_borrow");
        run_op(8, 'h8001, 1, 1'b0, "sra1");
        run_op(6, 'h8001, 1, 1'b0, "srl1");
        run_op(5, 'h8001, 0, 1'b0, "sll0");
        run_op(10, 'h0100, 'h0100, 1'b1, "mul_poke");
        run_op(9, 'h8000, 'h0000, 1'b0, "dbl_b2b");
        run_op(12, 'h1234, 'h5678, 1'b0, "illegal_c");
        @(posedge clk); #1;
        check("done_pulse_end", 64'(bus.done), 0);

        // Reset during a multiply must abort without any Done
        bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0007;
        bus.op = 4'b1010;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        check("rst_mid_mul no_done", 64'(seen), 0);
        check("rst_mid_mul outputs", 64'({bus.alu, bus.zero, bus.carry,
              bus.illegal}), 0);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15));
            a  = longint'($urandom_range(0, 65535));
            b  = longint'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) a = edge_v[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = edge_v[$urandom_range(0, 3)];
            run_op(op, a, b, 1'b0, $sformatf("rnd%0d op%0d", i, op));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                check("rnd done_pulse", 64'(bus.done), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
